// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
//   Shared raster constants for the overlay pipeline. This package holds the
//   640x480@60 timing numbers, the derived line and frame totals, and the
//   6-bit RRGGBB colour constants used by the overlay generators.
//   It also provides a small window-decode helper for sync pulses.
//   It has no ports.
// ----------------------------------------------------------------------------
package vga_pkg;

   // Horizontal timing, in pixels
   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;

   // Vertical timing, in lines
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

   // Sync lags x/y/active by one cycle to line up with the registered rgb stage
   localparam int SYNC_DELAY_DEF = 1;

   // 6-bit colours, RRGGBB
   localparam logic [5:0] BLACK = 6'b00_00_00;
   localparam logic [5:0] GOLD  = 6'b11_10_00;
   localparam logic [5:0] RED   = 6'b11_00_00;
   localparam logic [5:0] WHITE = 6'b11_11_11;

   // Sync pin pair as it travels down the delay line
   typedef struct packed {
      logic hsync_n;
      logic vsync_n;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1};

   // True when pos lies in [lo, lo+len). The sum is widened so that a window
   // ending exactly at 2048 still decodes correctly.
   function automatic logic in_window(input logic [10:0] pos,
                                      input logic [10:0] lo,
                                      input logic [10:0] len);
      logic [11:0] hi;
      hi = {1'b0, lo} + {1'b0, len};
      return (pos >= lo) && ({1'b0, pos} < hi);
   endfunction

endpackage

// File: rtl/sync_delay_line.sv
// ----------------------------------------------------------------------------
// sync_delay_line
//   This is a DEPTH-stage shift register with synchronous active-high reset.
//   Every stage resets to RESET_VAL. With DEPTH=0 the block is a plain wire.
//   Ports:
//     clk  in   1      clock
//     rst  in   1      synchronous reset, active-high
//     d_i  in   WIDTH  data entering stage 0
//     q_o  out  WIDTH  data leaving the last stage (or d_i when DEPTH=0)
// ----------------------------------------------------------------------------
module sync_delay_line #(
   parameter int               WIDTH     = 2,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_wire
         // Clock and reset are not needed in the wire build
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign q_o = d_i;
      end else begin : g_pipe
         logic [DEPTH-1:0][WIDTH-1:0] stage_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
            end else begin
               stage_q[0] <= d_i;
               for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign q_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   This is a free-running raster timing source. The h/v counters are the
//   only timing state. x, y, active and the line/frame strobes are decoded
//   from them with zero latency. The sync pins go through a SYNC_DELAY-stage
//   delay line so that they line up with registered pixel data downstream.
//   Ports:
//     clk          in   1   pixel clock
//     rst          in   1   synchronous reset, active-high
//     x            out  10  horizontal position, 0..H_TOTAL-1
//     y            out  10  vertical position, 0..V_TOTAL-1
//     active       out  1   inside the visible area
//     hsync_n      out  1   horizontal sync, low-true, delayed SYNC_DELAY
//     vsync_n      out  1   vertical sync, low-true, delayed SYNC_DELAY
//     line_start   out  1   high for the cycle where x==0
//     frame_start  out  1   high for the cycle where x==0 && y==0
//     frame_count  out  8   frame index, advances with each frame_start
//   The line and frame totals must both be <= 1024.
// ----------------------------------------------------------------------------
module vga_timing_gen
   import vga_pkg::sync_t;
   import vga_pkg::SYNC_IDLE;
   import vga_pkg::in_window;
#(
   parameter int H_VISIBLE  = vga_pkg::H_VISIBLE,
   parameter int H_FRONT    = vga_pkg::H_FRONT,
   parameter int H_SYNC     = vga_pkg::H_SYNC,
   parameter int H_BACK     = vga_pkg::H_BACK,
   parameter int V_VISIBLE  = vga_pkg::V_VISIBLE,
   parameter int V_FRONT    = vga_pkg::V_FRONT,
   parameter int V_SYNC     = vga_pkg::V_SYNC,
   parameter int V_BACK     = vga_pkg::V_BACK,
   parameter int SYNC_DELAY = vga_pkg::SYNC_DELAY_DEF
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int HTOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int VTOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0]  H_LAST = 10'(HTOT - 1);
   localparam logic [9:0]  V_LAST = 10'(VTOT - 1);
   localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
   localparam logic [10:0] HS_LO  = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_LEN = 11'(H_SYNC);
   localparam logic [10:0] VS_LO  = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_LEN = 11'(V_SYNC);

   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic [7:0] fc_q, fc_d;
   logic       h_wrap, v_wrap;
   sync_t      sync_raw, sync_dly;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   assign h_wrap = (h_q == H_LAST);
   assign v_wrap = (v_q == V_LAST);

   always_comb begin
      h_d  = h_q + 10'd1;
      v_d  = v_q;
      fc_d = fc_q;
      if (h_wrap) begin
         h_d = '0;
         v_d = v_wrap ? '0 : v_q + 10'd1;
         // The step (last,last)->(0,0) is the frame boundary. The wrap from
         // 255 to 0 is intentional.
         if (v_wrap) fc_d = fc_q + 8'd1;
      end
   end

   // Reset parks the raster on its last pixel. The first free-running edge
   // then lands on (0,0) with frame_count 0, and a full first frame follows.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_q  <= H_LAST;
         v_q  <= V_LAST;
         fc_q <= 8'hFF;
      end else begin
         h_q  <= h_d;
         v_q  <= v_d;
         fc_q <= fc_d;
      end
   end

   // ---------------------------------------------------------------------
   // Zero-latency decode
   // ---------------------------------------------------------------------
   assign x           = h_q;
   assign y           = v_q;
   assign frame_count = fc_q;
   assign active      = ({1'b0, h_q} < H_VIS) && ({1'b0, v_q} < V_VIS);
   assign line_start  = (h_q == 10'd0);
   assign frame_start = (h_q == 10'd0) && (v_q == 10'd0);

   // The parked reset position lies in the back porch, so the raw syncs are
   // already idle during reset. The delay stages are forced idle as well.
   assign sync_raw.hsync_n = ~in_window({1'b0, h_q}, HS_LO, HS_LEN);
   assign sync_raw.vsync_n = ~in_window({1'b0, v_q}, VS_LO, VS_LEN);

   sync_delay_line #(
      .WIDTH     ($bits(sync_t)),
      .DEPTH     (SYNC_DELAY),
      .RESET_VAL (SYNC_IDLE)
   ) u_sync_dly (
      .clk (clk),
      .rst (rst),
      .d_i (sync_raw),
      .q_o (sync_dly)
   );

   assign hsync_n = sync_dly.hsync_n;
   assign vsync_n = sync_dly.vsync_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen.
// It drives three builds from one shared clock and reset:
//   u_d : full 640x480 timing, SYNC_DELAY=1
//   u_s : reduced 15x10 raster, SYNC_DELAY=3 (frames are short enough to wrap frame_count)
//   u_z : the same reduced raster, SYNC_DELAY=0
// The expected output of each build follows from the number of free-running edges since reset.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [9:0] d_x, d_y, s_x, s_y, z_x, z_y;
   logic       d_act, d_hs, d_vs, d_ls, d_fs;
   logic       s_act, s_hs, s_vs, s_ls, s_fs;
   logic       z_act, z_hs, z_vs, z_ls, z_fs;
   logic [7:0] d_fc, s_fc, z_fc;

   vga_timing_gen u_d (
      .clk(clk), .rst(rst), .x(d_x), .y(d_y), .active(d_act),
      .hsync_n(d_hs), .vsync_n(d_vs), .line_start(d_ls),
      .frame_start(d_fs), .frame_count(d_fc));

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(3)
   ) u_s (
      .clk(clk), .rst(rst), .x(s_x), .y(s_y), .active(s_act),
      .hsync_n(s_hs), .vsync_n(s_vs), .line_start(s_ls),
      .frame_start(s_fs), .frame_count(s_fc));

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(0)
   ) u_z (
      .clk(clk), .rst(rst), .x(z_x), .y(z_y), .active(z_act),
      .hsync_n(z_hs), .vsync_n(z_vs), .line_start(z_ls),
      .frame_start(z_fs), .frame_count(z_fc));

   // t = free-running edges since reset was last sampled. It is -1 while in reset.
   int t     = -1;
   bit armed = 1'b0;
   always @(posedge clk) begin
      t <= rst ? -1 : t + 1;
      if (rst) armed <= 1'b1;
   end

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int x, y, fc;
      bit act, ls, fs, hs, vs;
   } exp_t;

   // Expected outputs derived from the raster arithmetic
   function automatic exp_t model(int tt, int hv, int hf, int hsw, int hb,
                                  int vv, int vf, int vsw, int vb, int dly);
      exp_t e;
      int ht, vt, s, sh, sv;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      if (tt < 0) begin
         e.x = ht - 1; e.y = vt - 1; e.fc = 255;
         e.act = 0; e.ls = 0; e.fs = 0;
      end else begin
         e.x   = tt % ht;
         e.y   = (tt / ht) % vt;
         e.fc  = (tt / (ht * vt)) % 256;
         e.act = (e.x < hv) && (e.y < vv);
         e.ls  = (e.x == 0);
         e.fs  = (e.x == 0) && (e.y == 0);
      end
      s = tt - dly;
      if (s < 0) begin
         e.hs = 1; e.vs = 1;
      end else begin
         sh = s % ht;
         sv = (s / ht) % vt;
         e.hs = !(sh >= hv + hf && sh < hv + hf + hsw);
         e.vs = !(sv >= vv + vf && sv < vv + vf + vsw);
      end
      return e;
   endfunction

   task automatic cmp_inst(string nm, exp_t e, int x, int y, bit act, bit ls,
                           bit fs, bit hs, bit vs, int fc);
      n_chk++;
      if (x != e.x || y != e.y || act != e.act || ls != e.ls || fs != e.fs ||
          hs != e.hs || vs != e.vs || fc != e.fc) begin
         n_fail++;
         $display("FAIL model_%s t=%0d got x=%0d y=%0d act=%0b ls=%0b fs=%0b hs=%0b vs=%0b fc=%0d, want x=%0d y=%0d act=%0b ls=%0b fs=%0b hs=%0b vs=%0b fc=%0d",
                  nm, t, x, y, act, ls, fs, hs, vs, fc,
                  e.x, e.y, e.act, e.ls, e.fs, e.hs, e.vs, e.fc);
      end
   endtask

   task automatic check(string nm, int got, int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   // Wait on negedges until cond holds. The bound is counted as a failed check.
   task automatic wait_d(int want_x, int want_y, int bound, string nm);
      int n = 0;
      while (!(d_x == 10'(want_x) && d_y == 10'(want_y)) && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (n >= bound) check({nm, "_timeout"}, n, -1);
   endtask

   initial begin
      int d_first_hs, d_hs_lows, s_first_hs, z_first_hs;
      int s_vs_x, s_vs_y, z_vs_x, z_vs_y, s_vs_lows, z_vs_lows;
      int act639, act640, pulses, fc_at_255, last_fc;

      fork
         forever begin
            @(negedge clk);
            if (armed) begin
               cmp_inst("d", model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1),
                        d_x, d_y, d_act, d_ls, d_fs, d_hs, d_vs, d_fc);
               cmp_inst("s", model(t, 8, 2, 3, 2, 6, 1, 2, 1, 3),
                        s_x, s_y, s_act, s_ls, s_fs, s_hs, s_vs, s_fc);
               cmp_inst("z", model(t, 8, 2, 3, 2, 6, 1, 2, 1, 0),
                        z_x, z_y, z_act, z_ls, z_fs, z_hs, z_vs, z_fc);
            end
         end
      join_none

      // Reset held for three cycles
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_x", d_x, 799);
      check("rst_y", d_y, 524);
      check("rst_active", d_act, 0);
      check("rst_hsync_n", d_hs, 1);
      check("rst_vsync_n", d_vs, 1);
      check("rst_frame_count", d_fc, 255);
      check("rst_frame_start", d_fs, 0);

      // Release. The first free-running edge must land on (0,0).
      rst = 1'b0;
      d_first_hs = -1; d_hs_lows = 0; s_first_hs = -1; z_first_hs = -1;
      s_vs_x = -1; s_vs_y = -1; z_vs_x = -1; z_vs_y = -1;
      s_vs_lows = 0; z_vs_lows = 0; act639 = -1; act640 = -1;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("first_x", d_x, 0);
            check("first_y", d_y, 0);
            check("first_frame_start", d_fs, 1);
            check("first_line_start", d_ls, 1);
            check("first_active", d_act, 1);
            check("first_frame_count", d_fc, 0);
         end
         if (d_x == 10'd639) act639 = d_act;
         if (d_x == 10'd640) act640 = d_act;
         if (!d_hs) begin
            d_hs_lows++;
            if (d_first_hs < 0) d_first_hs = d_x;
         end
         if (!s_hs && s_first_hs < 0) s_first_hs = s_x;
         if (!z_hs && z_first_hs < 0) z_first_hs = z_x;
         if (i < 150) begin
            if (!s_vs) begin
               s_vs_lows++;
               if (s_vs_x < 0) begin s_vs_x = s_x; s_vs_y = s_y; end
            end
            if (!z_vs) begin
               z_vs_lows++;
               if (z_vs_x < 0) begin z_vs_x = z_x; z_vs_y = z_y; end
            end
         end
      end
      check("active_at_639", act639, 1);
      check("active_at_640", act640, 0);
      check("hsync_first_low_x", d_first_hs, 657);
      check("hsync_low_cycles", d_hs_lows, 96);
      check("d3_hsync_first_low_x", s_first_hs, 13);
      check("d0_hsync_first_low_x", z_first_hs, 10);
      check("d3_vsync_first_low_x", s_vs_x, 3);
      check("d3_vsync_first_low_y", s_vs_y, 7);
      check("d0_vsync_first_low_x", z_vs_x, 0);
      check("d0_vsync_first_low_y", z_vs_y, 7);
      check("d3_vsync_low_cycles", s_vs_lows, 30);
      check("d0_vsync_low_cycles", z_vs_lows, 30);

      // Line wrap from (799,10) to (0,11)
      wait_d(799, 10, 12000, "wrap_wait");
      @(negedge clk);
      check("wrap_x", d_x, 0);
      check("wrap_y", d_y, 11);
      check("wrap_line_start", d_ls, 1);
      check("wrap_frame_start", d_fs, 0);

      // Mid-frame reset while hsync is low, to show the delay line is cleared
      wait_d(700, 12, 2000, "midrst_wait");
      check("midrst_hsync_low_before", d_hs, 0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_x", d_x, 799);
      check("midrst_y", d_y, 524);
      check("midrst_hsync_n", d_hs, 1);
      check("midrst_vsync_n", d_vs, 1);
      check("midrst_line_start", d_ls, 0);
      check("midrst_frame_count", d_fc, 255);
      repeat (2) @(negedge clk);
      check("hold_x", d_x, 799);
      check("hold_frame_start", d_fs, 0);
      rst = 1'b0;

      // 257 short frames. frame_count must run 0..255 and then return to 0.
      pulses = 0; fc_at_255 = -1; last_fc = -1;
      for (int i = 0; i < 257 * 150; i++) begin
         @(negedge clk);
         if (s_fs) begin
            if (pulses == 255) fc_at_255 = s_fc;
            last_fc = s_fc;
            pulses++;
         end
      end
      check("frame_pulses", pulses, 257);
      check("frame_count_255", fc_at_255, 255);
      check("frame_count_wrap", last_fc, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
